disp_mux: RTL
=============

# disp_mux

Memory-mapped 4-digit hexadecimal display driver sitting directly downstream of the picoVersat core inside `xtop`. The core writes a 16-bit value and a 4-bit decimal-point mask to the block. The block time-multiplexes the value onto the common-anode 7-segment display through the `Disp` and `Disp_sel` board outputs. Register state is readable back for software read-modify-write.

## Interface
Parameters:
- `DATA_W`, 32: core data bus width; only bits [19:0] are used, upper bits are ignored on write and read back as 0.
- `REFRESH_DIV`, 50000: clock cycles each digit stays selected; legal values ≥ 2.
- `CNT_W`, 16: refresh counter width; must hold `REFRESH_DIV-1`.

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `sel` in 1: peripheral select, decoded from the core data address.
- `we` in 1: write enable; write takes effect when `sel & we` is high at a rising edge.
- `data_in` in `DATA_W`: write data; [15:0] is the value, [19:16] is the dp mask.
- `data_out` out `DATA_W`: readback `{0, dp_q, value_q}`; combinational from registers.
- `Disp` out 8: segments, active-low; [7]=dp, [6:0]=g..a.
- `Disp_sel` out 4: digit anodes, active-low one-hot; bit 0 = rightmost digit.

## Operation
- Registers:
  - `value_q[15:0]` and `dp_q[3:0]`: loaded from `data_in` on a write.
  - `cnt_q`: refresh counter.
  - `idx_q[1:0]`: digit index.
  - `Disp`, `Disp_sel`: output registers.
- Refresh: `cnt_q` counts 0..`REFRESH_DIV-1`. At terminal count it wraps to 0 and `idx_q` increments modulo 4 (3→0).
- Digit `idx` displays nibble `value_q[4*idx+3:4*idx]`, so digit 0 is the least-significant nibble.
- Each cycle the output registers load:
  - `Disp_sel <= ~(4'b0001 << idx_q)`
  - `Disp[6:0] <= ~seg(nibble)`
  - `Disp[7] <= ~dp_q[idx_q]`
- Active-high gfedcba map `seg()`: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Writes do not disturb `cnt_q` or `idx_q`; scanning continues uninterrupted.
- Multiple consecutive writes: the last one wins. Each write is fully applied; there is no partial-nibble write.
- `sel` without `we` has no effect. `data_out` is valid regardless of `sel`.

## Timing
- Reset values:
  - `value_q`=0, `dp_q`=0, `cnt_q`=0, `idx_q`=0.
  - `Disp`=8'hFF (all off), `Disp_sel`=4'hF (all off), `data_out`=0.
- First rising edge after reset release: `Disp_sel`=4'hE, `Disp`=8'hC0 ("0" on digit 0, dp off).
- Write latency:
  - `value_q`/`dp_q` update at the edge sampling the write; `data_out` changes in that same cycle.
  - `Disp` reflects the new data at the following edge, if the affected digit is selected.
- Digit period: `idx_q` changes every `REFRESH_DIV` cycles. `Disp_sel` follows `idx_q` by exactly 1 cycle.
- Full scan period: 4·`REFRESH_DIV` cycles.
- Wrap: `idx_q`=3 at terminal count goes to 0 with no idle/blank cycle. `Disp_sel` never has more than one bit low.
- Reset mid-scan: asynchronous return of all registers to reset values immediately, with outputs blanked. The scan restarts at digit 0 with `cnt_q`=0.
- A write on the same edge as an `idx_q` change: both take effect. The next output register load uses the new `idx_q` and the new value.

## Configuration
- `DISP_LZB_EN` defined: leading-zero blanking.
  - Digit `idx` > 0 drives `Disp[6:0]`=7'h7F (segments off) when all nibbles at positions ≥ `idx` are zero.
  - Digit 0 is never blanked.
  - `Disp[7]` still follows `dp_q`.
  - `Disp_sel` scanning is unchanged.
- Not defined: all four digits always show their nibble, including leading zeros.

## Test plan
Benches use `REFRESH_DIV`=4.
- Reset, then release → `Disp`=FF/`Disp_sel`=F during reset; next edge `Disp_sel`=E, `Disp`=C0. `Disp_sel` then cycles E→D→B→7→E every 4 cycles, each digit showing C0.
- Write `data_in`=32'h0000_12AF → `data_out`=0000_12AF. Over one scan, Disp reads:
  - digit 0: 8E (F)
  - digit 1: 88 (A)
  - digit 2: A4 (2)
  - digit 3: F9 (1)
- Write 32'h0005_0000 (dp mask 5, value 0) → digits 0 and 2 show 40, digits 1 and 3 show C0.
- Write on the edge where `idx_q` wraps 3→0 → the next edge shows `Disp_sel`=E with the new nibble 0. There is no cycle with two digits selected or a stale value.
- Assert `rst` mid-digit-2 for half a cycle → outputs go FF/F asynchronously and `data_out`=0. After release the scan restarts at digit 0.
- With `DISP_LZB_EN`, write 16'h0030:
  - digits 2 and 3 show FF
  - digit 1 shows B0
  - digit 0 shows C0
  - Without the macro, digits 2 and 3 show C0.

Source files
------------

// File: rtl/disp_mux.sv
// disp_mux: memory-mapped 4-digit hex display driver (common-anode, active-low outputs).
// Optional leading-zero blanking is compiled in when DISP_LZB_EN is defined.
module disp_mux #(
   parameter int DATA_W      = 32,
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              we,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic [7:0]        Disp,
   output logic [3:0]        Disp_sel
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [15:0]      value_q, value_d;
   logic [3:0]       dp_q, dp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [7:0]       disp_q, disp_d;
   logic [3:0]       disp_sel_q, disp_sel_d;

   logic             wr_en;
   logic             cnt_last;
   logic [3:0]       nibble;
   logic [6:0]       seg;
   logic             blank;

   assign wr_en    = sel & we;
   assign cnt_last = (cnt_q == CNT_LAST);

   generate
      if (DATA_W > 20) begin : g_unused
         logic unused_data_hi;
         assign unused_data_hi = ^data_in[DATA_W-1:20];
      end
   endgenerate

   always_comb begin
      value_d = value_q;
      dp_d    = dp_q;
      if (wr_en) begin
         value_d = data_in[15:0];
         dp_d    = data_in[19:16];
      end
   end

   // Scanning runs independently of writes; a write never resets the refresh position.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (cnt_last) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end
   end

   always_comb begin
      nibble = value_q[3:0];
      case (idx_q)
         2'd0: nibble = value_q[3:0];
         2'd1: nibble = value_q[7:4];
         2'd2: nibble = value_q[11:8];
         2'd3: nibble = value_q[15:12];
         default: nibble = value_q[3:0];
      endcase
   end

   always_comb begin
      seg = 7'h00;
      case (nibble)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
   end

`ifdef DISP_LZB_EN
   // A digit is a leading zero when it and every more-significant nibble are zero.
   always_comb begin
      blank = 1'b0;
      case (idx_q)
         2'd0: blank = 1'b0;
         2'd1: blank = (value_q[15:4] == 12'h000);
         2'd2: blank = (value_q[15:8] == 8'h00);
         2'd3: blank = (value_q[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      disp_sel_d  = ~(4'b0001 << idx_q);
      disp_d[7]   = ~dp_q[idx_q];
      disp_d[6:0] = blank ? 7'h7F : ~seg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q    <= '0;
         dp_q       <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         disp_q     <= 8'hFF;
         disp_sel_q <= 4'hF;
      end else begin
         value_q    <= value_d;
         dp_q       <= dp_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         disp_q     <= disp_d;
         disp_sel_q <= disp_sel_d;
      end
   end

   assign data_out = DATA_W'({dp_q, value_q});
   assign Disp     = disp_q;
   assign Disp_sel = disp_sel_q;

endmodule
